bit_serial_ctrl: RTL and testbench

Program sequencer for the bit-serial datapath (mux8, mux, gpr, muxalu, alu, accumulator, carry register).
- Fetches 3-bit instructions from an external program ROM, addressed by an internal PC.
- Runs each instruction as BITS consecutive bit-slot cycles, LSB first, and drives every datapath control line.
- Handles run, single-step and halt/resume.
- Sits beside the datapath at the top level; replaces free-running instruction feed and start sequencing.

---
 rtl/bit_serial_pkg.sv | 23 ++
 rtl/bit_serial_slot_cnt.sv | 25 ++
 rtl/bit_serial_ctrl.sv | 126 ++++++++++++
 tb/tb_bit_serial_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_pkg.sv
// bit_serial_pkg: opcodes, sequencer states and per-opcode datapath controls
//   opcode_e : 2-bit opcode field of the 3-bit instruction {opcode, reg_sel}
//   state_e  : sequencer states
//   ctrl_t   : mux / muxalu / gpr write / gpr shift for one opcode
//   decode() : opcode -> ctrl_t (HLT has no bit-slots, so it decodes to all zero)
package bit_serial_pkg;
  typedef enum logic [1:0] {OP_LDSW, OP_ADD, OP_STA, OP_HLT} opcode_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_RETIRE, S_HALTED} state_e;
  typedef struct packed {
    logic mux;
    logic muxalu;
    logic write;
    logic shift;
  } ctrl_t;
  function automatic ctrl_t decode(opcode_e op);
    case (op)
      OP_LDSW: return ctrl_t'(4'b1011);
      OP_ADD:  return ctrl_t'(4'b0101);
      OP_STA:  return ctrl_t'(4'b0011);
      default: return ctrl_t'(4'b0000);
    endcase
  endfunction
endpackage

// File: rtl/bit_serial_slot_cnt.sv
// bit_serial_slot_cnt: BITS-cycle bit-slot counter
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : force count to 0 (takes priority over i_en)
//   i_en           : advance one slot, wrapping after BITS-1
//   o_cnt          : current slot index
//   o_last         : high while o_cnt == BITS-1
module bit_serial_slot_cnt #(
  parameter int BITS = 8,
  localparam int CW = $clog2(BITS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_last
);
  logic [CW-1:0] cnt_q, cnt_d;
  assign o_last = cnt_q == CW'(BITS - 1);
  assign o_cnt  = cnt_q;
  always_comb cnt_d = i_clr ? '0 : i_en ? (o_last ? '0 : cnt_q + 1'b1) : cnt_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/bit_serial_ctrl.sv
// bit_serial_ctrl: program sequencer driving the bit-serial datapath controls
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_run / i_step          : continuous run level / single-instruction pulse
//   i_halt_clr              : leave HALTED, advancing past the HLT
//   o_rom_en, o_rom_addr    : program ROM read strobe and address (= PC)
//   i_rom_data              : instruction {opcode[1:0], reg_sel}, ROM_LAT after o_rom_en
//   o_con_*                 : datapath control lines, active only in EXEC (pcincr in RETIRE)
//   o_pc, o_busy, o_halted  : status
module bit_serial_ctrl
  import bit_serial_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int BITS    = 8,
  parameter int ROM_LAT = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_run,
  input  logic            i_step,
  input  logic            i_halt_clr,
  output logic            o_rom_en,
  output logic [PC_W-1:0] o_rom_addr,
  input  logic [2:0]      i_rom_data,
  output logic [2:0]      o_con_mux8,
  output logic            o_con_mux,
  output logic            o_con_muxalu,
  output logic            o_con_gpr_region,
  output logic            o_con_gpr_sel,
  output logic            o_con_gpr_write,
  output logic            o_con_gpr_shift,
  output logic            o_con_carry_clr,
  output logic            o_con_pcincr,
  output logic [PC_W-1:0] o_pc,
  output logic            o_busy,
  output logic            o_halted
);
  localparam int CW = $clog2(BITS);
  localparam logic W_LAST = 1'(ROM_LAT - 1);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0] ir_q, ir_d;
  logic step_q, step_d;
  logic w_q, w_d;
  logic [CW-1:0] slot;
  logic last;
  ctrl_t c;
  bit_serial_slot_cnt #(.BITS(BITS)) u_slot (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(state_q != S_EXEC), .i_en(1'b1),
    .o_cnt(slot), .o_last(last)
  );
  assign c = decode(opcode_e'(ir_q[2:1]));
  assign o_rom_addr = pc_q;
  assign o_pc = pc_q;
  assign o_busy = state_q != S_IDLE && state_q != S_HALTED;
  assign o_halted = state_q == S_HALTED;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    step_d = step_q;
    w_d = w_q;
    o_rom_en = 1'b0;
    o_con_mux8 = '0;
    o_con_mux = 1'b0;
    o_con_muxalu = 1'b0;
    o_con_gpr_region = 1'b0;
    o_con_gpr_sel = 1'b0;
    o_con_gpr_write = 1'b0;
    o_con_gpr_shift = 1'b0;
    o_con_carry_clr = 1'b0;
    o_con_pcincr = 1'b0;
    case (state_q)
      S_IDLE: if (i_run || i_step) begin
        state_d = S_FETCH;
        step_d = !i_run;
      end
      S_FETCH: begin
        o_rom_en = 1'b1;
        w_d = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        w_d = w_q + 1'b1;
        if (w_q == W_LAST) begin
          ir_d = i_rom_data;
          state_d = i_rom_data[2:1] == OP_HLT ? S_HALTED : S_EXEC;
        end
      end
      S_EXEC: begin
        o_con_mux8 = 3'(slot);
        o_con_mux = c.mux;
        o_con_muxalu = c.muxalu;
        o_con_gpr_region = ir_q[2];
        o_con_gpr_sel = ir_q[0];
        o_con_gpr_write = c.write;
        o_con_gpr_shift = c.shift;
        o_con_carry_clr = slot == '0;
        if (last) state_d = S_RETIRE;
      end
      S_RETIRE: begin
        o_con_pcincr = 1'b1;
        pc_d = pc_q + 1'b1;
        state_d = i_run && !step_q ? S_FETCH : S_IDLE;
      end
      S_HALTED: if (i_halt_clr) begin
        pc_d = pc_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      ir_q <= '0;
      step_q <= 1'b0;
      w_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      step_q <= step_d;
      w_q <= w_d;
    end
endmodule

// File: tb/tb_bit_serial_ctrl.sv
// tb_bit_serial_ctrl: directed table and sequence checks of the program sequencer
module tb_bit_serial_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, step = 1'b0, hclr = 1'b0;
  logic rom_en;
  logic [3:0] rom_addr, pc;
  logic [2:0] rom_data = 3'b000, mux8;
  logic mux, muxalu, region, sel, wr, sh, cclr, pcincr, busy, halted;
  logic [2:0] rom [16];
  int n_chk = 0, n_fail = 0;
  typedef struct packed {
    logic rom_en;
    logic [2:0] mux8;
    logic [9:0] f;
    logic [3:0] pc;
  } obs_t;
  typedef struct {
    logic run;
    logic step;
    obs_t exp;
  } vec_t;
  obs_t obs;
  obs_t snap [40];
  vec_t tbl [13];
  assign obs = {rom_en, mux8, mux, muxalu, region, sel, wr, sh, cclr, pcincr, busy, halted, pc};
  bit_serial_ctrl #(.PC_W(4), .BITS(8), .ROM_LAT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_step(step), .i_halt_clr(hclr),
    .o_rom_en(rom_en), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_con_mux8(mux8), .o_con_mux(mux), .o_con_muxalu(muxalu), .o_con_gpr_region(region),
    .o_con_gpr_sel(sel), .o_con_gpr_write(wr), .o_con_gpr_shift(sh), .o_con_carry_clr(cclr),
    .o_con_pcincr(pcincr), .o_pc(pc), .o_busy(busy), .o_halted(halted)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic obs_t mk(logic en, logic [2:0] m8, logic [9:0] f, logic [3:0] p);
    return {en, m8, f, p};
  endfunction
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reset();
    rst_n = 1'b0;
    run = 1'b0;
    step = 1'b0;
    hclr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    int k, ex, pi, re, sum, t0, t1;
    bit ok;
    for (int i = 0; i < 16; i++) rom[i] = 3'b001;
    tbl[0] = '{1'b0, 1'b1, mk(1'b0, 3'd0, 10'b0000000000, 4'd0)};
    tbl[1] = '{1'b0, 1'b0, mk(1'b1, 3'd0, 10'b0000000010, 4'd0)};
    tbl[2] = '{1'b0, 1'b0, mk(1'b0, 3'd0, 10'b0000000010, 4'd0)};
    for (int s = 0; s < 8; s++)
      tbl[3+s] = '{1'b0, 1'b0, mk(1'b0, 3'(s), {6'b100111, s == 0, 3'b010}, 4'd0)};
    tbl[11] = '{1'b0, 1'b0, mk(1'b0, 3'd0, 10'b0000000110, 4'd0)};
    tbl[12] = '{1'b0, 1'b0, mk(1'b0, 3'd0, 10'b0000000000, 4'd1)};
    reset();
    for (int i = 0; i < 13; i++) begin
      run = tbl[i].run;
      step = tbl[i].step;
      chk($sformatf("t1_step_v%0d", i), 32'(obs), 32'(tbl[i].exp));
      tick();
    end
    rom[0] = 3'b000;
    rom[1] = 3'b011;
    rom[2] = 3'b101;
    rom[3] = 3'b110;
    reset();
    run = 1'b1;
    for (int c = 0; c < 40; c++) begin
      snap[c] = obs;
      tick();
    end
    chk("t2_fetch0", 32'(snap[1]), 32'(mk(1'b1, 3'd0, 10'b0000000010, 4'd0)));
    chk("t2_ldsw_s0", 32'(snap[3]), 32'(mk(1'b0, 3'd0, 10'b1000111010, 4'd0)));
    chk("t2_retire0", 32'(snap[11]), 32'(mk(1'b0, 3'd0, 10'b0000000110, 4'd0)));
    chk("t2_fetch1", 32'(snap[12]), 32'(mk(1'b1, 3'd0, 10'b0000000010, 4'd1)));
    chk("t2_add_s0", 32'(snap[14]), 32'(mk(1'b0, 3'd0, 10'b0101011010, 4'd1)));
    chk("t2_retire1", 32'(snap[22]), 32'(mk(1'b0, 3'd0, 10'b0000000110, 4'd1)));
    chk("t2_sta_s7", 32'(snap[32]), 32'(mk(1'b0, 3'd7, 10'b0011110010, 4'd2)));
    chk("t2_retire2", 32'(snap[33]), 32'(mk(1'b0, 3'd0, 10'b0000000110, 4'd2)));
    chk("t2_wait_hlt", 32'(snap[35]), 32'(mk(1'b0, 3'd0, 10'b0000000010, 4'd3)));
    chk("t2_halted", 32'(snap[36]), 32'(mk(1'b0, 3'd0, 10'b0000000001, 4'd3)));
    chk("t2_halt_hold", 32'(snap[39]), 32'(mk(1'b0, 3'd0, 10'b0000000001, 4'd3)));
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("t2_step_in_halt", 32'(obs), 32'(mk(1'b0, 3'd0, 10'b0000000001, 4'd3)));
    run = 1'b0;
    hclr = 1'b1;
    tick();
    hclr = 1'b0;
    chk("t2_halt_clr", 32'(obs), 32'(mk(1'b0, 3'd0, 10'b0000000000, 4'd4)));
    hclr = 1'b1;
    tick();
    hclr = 1'b0;
    tick();
    chk("t2_clr_in_idle", 32'(obs), 32'(mk(1'b0, 3'd0, 10'b0000000000, 4'd4)));
    for (int i = 0; i < 4; i++) rom[i] = 3'b001;
    run = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      if (pcincr && pc == 4'd14) begin
        ok = 1'b1;
        run = 1'b0;
      end
      tick();
    end
    chk("t3_reach_pc14", 32'(ok), 32'd1);
    chk("t3_idle_pc15", 32'(obs), 32'(mk(1'b0, 3'd0, 10'b0000000000, 4'd15)));
    step = 1'b1;
    tick();
    step = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (pcincr) ok = 1'b1;
      else tick();
    end
    chk("t3_retire_seen", 32'(ok), 32'd1);
    chk("t3_retire_pc", 32'(pc), 32'd15);
    tick();
    chk("t3_wrap", 32'(obs), 32'(mk(1'b0, 3'd0, 10'b0000000000, 4'd0)));
    run = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      if (mux8 == 3'd3 && wr) begin
        ok = 1'b1;
        run = 1'b0;
      end
      tick();
    end
    chk("t4_reach_slot3", 32'(ok), 32'd1);
    ex = 0;
    pi = 0;
    re = 0;
    sum = 0;
    for (int c = 0; c < 15; c++) begin
      if (sh) begin
        ex++;
        sum += int'(mux8);
      end
      if (pi > 0 && rom_en) re++;
      if (pcincr) pi++;
      tick();
    end
    chk("t4_slots_left", ex, 4);
    chk("t4_slot_sum", sum, 22);
    chk("t4_pcincr", pi, 1);
    chk("t4_no_fetch", re, 0);
    chk("t4_idle", 32'(obs), 32'(mk(1'b0, 3'd0, 10'b0000000000, 4'd1)));
    run = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      if (mux8 == 3'd5 && wr) ok = 1'b1;
      else tick();
    end
    chk("t5_reach_slot5", 32'(ok), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_zero", 32'(obs), 32'd0);
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("t5_after_release", 32'(obs), 32'(mk(1'b0, 3'd0, 10'b0000000000, 4'd0)));
    reset();
    run = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    t0 = -1;
    t1 = -1;
    for (int c = 0; c < 40 && t1 < 0; c++) begin
      step = sh;
      if (pcincr) begin
        if (t0 < 0) t0 = c;
        else t1 = c;
      end
      tick();
    end
    step = 1'b0;
    chk("t6_first_retire", t0, 10);
    chk("t6_interval", t1 - t0, 11);
    chk("t6_still_running", 32'(busy), 32'd1);
    run = 1'b0;
    k = 0;
    while (busy && k < 20) begin
      tick();
      k++;
    end
    chk("t6_stop_idle", 32'(obs), 32'(mk(1'b0, 3'd0, 10'b0000000000, 4'd3)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
